// File: rtl/mm_access_ctrl_pkg.sv
// rtl/mm_access_ctrl_pkg.sv - shared access-size encodings, FSM states and store lane helpers
package mm_access_ctrl_pkg;

   localparam logic [1:0] ACCESS_SZ_BYTE = 2'b00;
   localparam logic [1:0] ACCESS_SZ_HALF = 2'b01;
   localparam logic [1:0] ACCESS_SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      MMA_IDLE = 2'd0,
      MMA_REQ  = 2'd1,
      MMA_WAIT = 2'd2,
      MMA_DROP = 2'd3
   } mma_state_t;

   function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         ACCESS_SZ_BYTE: gen_wstrb = 4'b0001 << addr_lo;
         ACCESS_SZ_HALF: gen_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
         default:        gen_wstrb = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         ACCESS_SZ_BYTE: gen_wdata = {4{wdata[7:0]}};
         ACCESS_SZ_HALF: gen_wdata = {2{wdata[15:0]}};
         default:        gen_wdata = wdata;
      endcase
   endfunction

endpackage

// File: rtl/mm_access_ctrl_if.sv
// rtl/mm_access_ctrl_if.sv - MM-stage request bus plus SRAM-like data bus
interface mm_access_ctrl_if;
   logic        mm_valid;
   logic        mm_re;
   logic        mm_we;
   logic [1:0]  mm_access_sz;
   logic        mm_unsigned;
   logic [31:0] mm_addr;
   logic [31:0] mm_wdata;
   logic        mm_flush;
   logic        mm_ready;
   logic        mm_done;
   logic [31:0] mm_rdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport slave (
      input  mm_valid, mm_re, mm_we, mm_access_sz, mm_unsigned, mm_addr, mm_wdata, mm_flush,
      output mm_ready, mm_done, mm_rdata,
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
      output data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport master (
      output mm_valid, mm_re, mm_we, mm_access_sz, mm_unsigned, mm_addr, mm_wdata, mm_flush,
      input  mm_ready, mm_done, mm_rdata,
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
      input  data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );
endinterface

// File: rtl/mm_load_ext.sv
// rtl/mm_load_ext.sv - aligns returned load data to lane 0 and sign/zero extends it
module mm_load_ext
   import mm_access_ctrl_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (size)
         ACCESS_SZ_BYTE: result = {{24{shifted[7]  & ~is_unsigned}}, shifted[7:0]};
         ACCESS_SZ_HALF: result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
         default:        result = shifted;
      endcase
   end

endmodule

// File: rtl/mm_access_ctrl.sv
// rtl/mm_access_ctrl.sv - MM-stage load/store responder driving the SRAM-like data bus
module mm_access_ctrl
   import mm_access_ctrl_pkg::*;
(
   input logic            clk,
   input logic            rst,
   mm_access_ctrl_if.slave bus
);

   mma_state_t  state, state_nx;
   logic        accept;
   logic        done_nx;
   logic        flushed;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        done_q;
   logic [31:0] rdata_q;
   logic [31:0] ext_result;

   mm_load_ext u_load_ext (
      .addr_lo     (req_addr[1:0]),
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .rdata       (bus.data_sram_rdata),
      .result      (ext_result)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      done_nx  = 1'b0;
      case (state)
         MMA_IDLE: begin
            if (bus.mm_valid && (bus.mm_re || bus.mm_we) && !bus.mm_flush) begin
               accept   = 1'b1;
               state_nx = MMA_REQ;
            end
         end
         MMA_REQ: begin
            // The request cannot be withdrawn, so a flush here only redirects to DROP.
            if (bus.data_sram_addr_ok)
               state_nx = (flushed || bus.mm_flush) ? MMA_DROP : MMA_WAIT;
         end
         MMA_WAIT: begin
            if (bus.data_sram_data_ok) begin
               state_nx = MMA_IDLE;
               done_nx  = !bus.mm_flush;
            end else if (bus.mm_flush) begin
               state_nx = MMA_DROP;
            end
         end
         MMA_DROP: begin
            if (bus.data_sram_data_ok)
               state_nx = MMA_IDLE;
         end
         default: state_nx = MMA_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= MMA_IDLE;
         flushed      <= 1'b0;
         req_wr       <= 1'b0;
         req_size     <= 2'b00;
         req_unsigned <= 1'b0;
         req_addr     <= 32'h0;
         req_wstrb    <= 4'h0;
         req_wdata    <= 32'h0;
         done_q       <= 1'b0;
         rdata_q      <= 32'h0;
      end else begin
         state  <= state_nx;
         done_q <= done_nx;
         if (state == MMA_REQ)
            flushed <= bus.data_sram_addr_ok ? 1'b0 : (flushed | bus.mm_flush);
         else
            flushed <= 1'b0;
         if (accept) begin
            req_wr       <= bus.mm_we;
            req_size     <= bus.mm_access_sz;
            req_unsigned <= bus.mm_unsigned;
            req_addr     <= bus.mm_addr;
            req_wstrb    <= bus.mm_we ? gen_wstrb(bus.mm_access_sz, bus.mm_addr[1:0]) : 4'h0;
            req_wdata    <= gen_wdata(bus.mm_access_sz, bus.mm_wdata);
         end
         if (done_nx)
            rdata_q <= req_wr ? 32'h0 : ext_result;
      end
   end

   assign bus.mm_ready        = (state == MMA_IDLE);
   assign bus.mm_done         = done_q;
   assign bus.mm_rdata        = rdata_q;
   assign bus.data_sram_req   = (state == MMA_REQ);
   assign bus.data_sram_wr    = req_wr;
   assign bus.data_sram_size  = req_size;
   assign bus.data_sram_wstrb = req_wstrb;
   assign bus.data_sram_addr  = req_addr;
   assign bus.data_sram_wdata = req_wdata;

endmodule

// File: tb/tb_mm_access_ctrl.sv
// tb/tb_mm_access_ctrl.sv - directed scoreboard bench for mm_access_ctrl
module tb_mm_access_ctrl;

   typedef struct {
      logic [31:0] rdata;
      int          due;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   exp_t mon_e;

   mm_access_ctrl_if bus ();

   mm_access_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.mm_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got mm_done=1 at cycle %0d expected no response", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, "_rdata"}, bus.mm_rdata, mon_e.rdata);
            chk({mon_e.name, "_cycle"}, cyc, mon_e.due);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic re, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.mm_valid     = 1'b1;
      bus.mm_re        = re;
      bus.mm_we        = we;
      bus.mm_access_sz = sz;
      bus.mm_unsigned  = uns;
      bus.mm_addr      = addr;
      bus.mm_wdata     = wdata;
   endtask

   task automatic access(input string name, input logic re, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int aok_dly, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_res);
      exp_t e;
      present(re, we, sz, uns, addr, wdata);
      tick();
      bus.mm_valid = 1'b0;
      e.rdata = exp_res;
      e.due   = cyc + 2 + aok_dly;
      e.name  = name;
      exp_q.push_back(e);
      chk({name, "_ready_low"}, bus.mm_ready, 0);
      chk({name, "_req"}, bus.data_sram_req, 1);
      chk({name, "_wr"}, bus.data_sram_wr, we);
      chk({name, "_size"}, bus.data_sram_size, sz);
      chk({name, "_addr"}, bus.data_sram_addr, addr);
      chk({name, "_wstrb"}, bus.data_sram_wstrb, exp_strb);
      chk({name, "_wdata"}, bus.data_sram_wdata, exp_wdata);
      for (int i = 0; i < aok_dly; i++) begin
         tick();
         chk({name, "_hold_req"}, bus.data_sram_req, 1);
         chk({name, "_hold_ready"}, bus.mm_ready, 0);
         chk({name, "_hold_addr"}, bus.data_sram_addr, addr);
         chk({name, "_hold_wstrb"}, bus.data_sram_wstrb, exp_strb);
         chk({name, "_hold_wdata"}, bus.data_sram_wdata, exp_wdata);
      end
      bus.data_sram_addr_ok = 1'b1;
      tick();
      bus.data_sram_addr_ok = 1'b0;
      chk({name, "_req_dropped"}, bus.data_sram_req, 0);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = rdata;
      tick();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'h0;
      chk({name, "_ready_back"}, bus.mm_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.mm_valid = 1'b0;
      bus.mm_re = 1'b0;
      bus.mm_we = 1'b0;
      bus.mm_access_sz = 2'b00;
      bus.mm_unsigned = 1'b0;
      bus.mm_addr = 32'h0;
      bus.mm_wdata = 32'h0;
      bus.mm_flush = 1'b0;
      bus.data_sram_addr_ok = 1'b0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata = 32'h0;
      repeat (2) tick();
      chk("rst_ready", bus.mm_ready, 1);
      chk("rst_done", bus.mm_done, 0);
      chk("rst_rdata", bus.mm_rdata, 0);
      chk("rst_req", bus.data_sram_req, 0);
      chk("rst_wr", bus.data_sram_wr, 0);
      chk("rst_size", bus.data_sram_size, 0);
      chk("rst_wstrb", bus.data_sram_wstrb, 0);
      chk("rst_addr", bus.data_sram_addr, 0);
      chk("rst_wdata", bus.data_sram_wdata, 0);
      rst = 1'b0;
      tick();

      access("ld_b",  1, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
      access("ld_hu", 1, 0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 4'h0, 32'h0, 32'h0000_8001);
      access("ld_h",  1, 0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 4'h0, 32'h0, 32'hFFFF_8001);
      access("st_b",  0, 1, 2'b00, 0, 32'h0000_3001, 32'h0000_00AB, 32'h0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
      access("st_w_stall", 0, 1, 2'b10, 0, 32'h0000_4000, 32'h1234_5678, 32'h0, 4, 4'b1111, 32'h1234_5678, 32'h0);
      access("st_h",  0, 1, 2'b01, 0, 32'h0000_5002, 32'hDEAD_BEEF, 32'h0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
      access("ld_w",  1, 0, 2'b10, 0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 2, 4'h0, 32'h0, 32'hCAFE_F00D);
      access("ld_bu", 1, 0, 2'b00, 1, 32'h0000_7001, 32'h0, 32'h0000_A500, 0, 4'h0, 32'h0, 32'h0000_00A5);

      // Flush while IDLE blocks acceptance.
      present(1, 0, 2'b10, 0, 32'h0000_8000, 32'h0);
      bus.mm_flush = 1'b1;
      tick();
      bus.mm_flush = 1'b0;
      bus.mm_valid = 1'b0;
      chk("idle_flush_ready", bus.mm_ready, 1);
      chk("idle_flush_req", bus.data_sram_req, 0);

      // Flush during REQ: request held, DROP consumes data_ok, no done.
      present(1, 0, 2'b10, 0, 32'h0000_9000, 32'h0);
      tick();
      bus.mm_valid = 1'b0;
      bus.mm_flush = 1'b1;
      tick();
      bus.mm_flush = 1'b0;
      chk("req_flush_req_held", bus.data_sram_req, 1);
      chk("req_flush_addr_held", bus.data_sram_addr, 32'h0000_9000);
      bus.data_sram_addr_ok = 1'b1;
      tick();
      bus.data_sram_addr_ok = 1'b0;
      chk("drop_ready", bus.mm_ready, 0);
      chk("drop_req", bus.data_sram_req, 0);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata = 32'h5555_5555;
      tick();
      bus.data_sram_data_ok = 1'b0;
      chk("drop_exit_ready", bus.mm_ready, 1);
      access("after_drop", 1, 0, 2'b10, 0, 32'h0000_A000, 32'h0, 32'h0BAD_F00D, 0, 4'h0, 32'h0, 32'h0BAD_F00D);

      // Reset while in WAIT, then a stray data_ok.
      present(0, 1, 2'b10, 0, 32'h0000_B004, 32'hFEED_FACE);
      tick();
      bus.mm_valid = 1'b0;
      bus.data_sram_addr_ok = 1'b1;
      tick();
      bus.data_sram_addr_ok = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("wait_rst_ready", bus.mm_ready, 1);
      chk("wait_rst_req", bus.data_sram_req, 0);
      chk("wait_rst_wr", bus.data_sram_wr, 0);
      chk("wait_rst_addr", bus.data_sram_addr, 0);
      chk("wait_rst_wstrb", bus.data_sram_wstrb, 0);
      chk("wait_rst_wdata", bus.data_sram_wdata, 0);
      tick();
      rst = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata = 32'h1111_2222;
      tick();
      bus.data_sram_data_ok = 1'b0;
      chk("stray_ready", bus.mm_ready, 1);
      repeat (3) tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
